// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the byte-wide load/store path.
//   size_t      - request size codes (byte / half / word / illegal)
//   state_t     - ram_byte_ctrl sequencer states
//   beat_count  - number of single-byte RAM beats for a given size
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT,
        S_DONE,
        S_ERR
    } state_t;

    // Size code -> beats; the illegal code counts as a word.
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: beat_count = 3'd1;
            SZ_HALF: beat_count = 3'd2;
            default: beat_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_byte_ctrl_load_extend.sv
// load_extend: combinational sign/zero extension of an assembled load value.
// Ports:
//   acc      in  32  big-endian assembled bytes, right-justified
//   size     in  2   SZ_BYTE / SZ_HALF / SZ_WORD (anything else passes acc)
//   sign_ext in  1   1 = sign-extend, 0 = zero-extend
//   rdata    out 32  extended result
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = acc;
        case (size)
            SZ_BYTE: rdata = {{24{sign_ext & acc[7]}},  acc[7:0]};
            SZ_HALF: rdata = {{16{sign_ext & acc[15]}}, acc[15:0]};
            default: rdata = acc;
        endcase
    end

endmodule

// File: rtl/ram_byte_ctrl.sv
// ram_byte_ctrl: sequences a 32-bit byte/half/word load or store into 1, 2
// or 4 single-byte accesses to a byte-wide RAM, big-endian (MSB at the
// lowest address). Loads are assembled and extended by load_extend.
// Build option: RAM_BYTE_CTRL_ALIGN_CHECK_EN
//   defined   - misaligned or size=11 requests are rejected with an err pulse
//   undefined - err is 0, addresses are force-aligned, size=11 acts as word
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req, we, size,        request (sampled in IDLE only), store/load,
//   sign_ext, addr, wdata size code, load extension, byte address, store data
//   rdata                 last load result (held across stores)
//   busy, done, err       not-idle flag, completion pulse, reject pulse
//   ram_ena, ram_wena,    RAM enable / write enable / byte address / write
//   ram_addr, ram_din     byte; all zero outside a beat
//   ram_dout              asynchronous RAM read byte
module ram_byte_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    state_t            state, state_nx;
    logic              we_r;
    logic [1:0]        size_r;
    logic              sign_r;
    logic [ADDR_W-1:0] base_r;
    logic [31:0]       wdata_r;
    logic [2:0]        n_r;
    logic [1:0]        i_r;
    logic [31:0]       acc;
    logic [31:0]       acc_nx;
    logic [31:0]       ext;
    logic [2:0]        pos;
    logic              last;
    logic [1:0]        size_eff;
    logic [ADDR_W-1:0] addr_eff;

`ifdef RAM_BYTE_CTRL_ALIGN_CHECK_EN
    logic legal;

    always_comb begin
        size_eff = size;
        addr_eff = addr;
        legal    = !((size == SZ_ILL) ||
                     (size == SZ_HALF && addr[0]) ||
                     (size == SZ_WORD && addr[1:0] != 2'b00));
    end

    assign err = (state == S_ERR);
`else
    always_comb begin
        size_eff = (size == SZ_ILL) ? SZ_WORD : size;
        addr_eff = addr;
        case (size_eff)
            SZ_HALF: addr_eff = {addr[ADDR_W-1:1], 1'b0};
            SZ_WORD: addr_eff = {addr[ADDR_W-1:2], 2'b00};
            default: addr_eff = addr;
        endcase
    end

    assign err = 1'b0;
`endif

    // The byte written in beat i sits (N-1-i) bytes above the LSB of wdata.
    assign pos    = n_r - 3'd1 - {1'b0, i_r};
    assign last   = ({1'b0, i_r} == (n_r - 3'd1));
    assign acc_nx = {acc[23:0], ram_dout};
    assign busy   = (state != S_IDLE);

    // Extend from the accumulator value including the byte of the final
    // beat, so rdata is ready on the same edge that enters DONE.
    load_extend u_ext (
        .acc      (acc_nx),
        .size     (size_r),
        .sign_ext (sign_r),
        .rdata    (ext)
    );

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        ram_ena  = 1'b0;
        ram_wena = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            S_IDLE: begin
                if (req) begin
`ifdef RAM_BYTE_CTRL_ALIGN_CHECK_EN
                    state_nx = legal ? S_BEAT : S_ERR;
`else
                    state_nx = S_BEAT;
`endif
                end
            end
            S_BEAT: begin
                // Reset during a beat must not commit that beat's write.
                if (!rst) begin
                    ram_ena  = 1'b1;
                    ram_wena = we_r;
                    ram_addr = base_r + {{(ADDR_W-2){1'b0}}, i_r};
                    ram_din  = we_r ? wdata_r[{pos[1:0], 3'b000} +: 8] : '0;
                end
                if (last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
`ifdef RAM_BYTE_CTRL_ALIGN_CHECK_EN
            S_ERR: begin
                state_nx = S_IDLE;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            we_r    <= 1'b0;
            size_r  <= '0;
            sign_r  <= 1'b0;
            base_r  <= '0;
            wdata_r <= '0;
            n_r     <= '0;
            i_r     <= '0;
            acc     <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_r    <= we;
                        size_r  <= size_eff;
                        sign_r  <= sign_ext;
                        base_r  <= addr_eff;
                        wdata_r <= wdata;
                        n_r     <= beat_count(size_eff);
                        i_r     <= '0;
                        acc     <= '0;
                    end
                end
                S_BEAT: begin
                    acc <= acc_nx;
                    i_r <= i_r + 2'd1;
                    if (last && !we_r) begin
                        rdata <= ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_byte_ctrl.sv
module tb_ram_byte_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy, done, err;
    logic        ram_ena, ram_wena;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_din, ram_dout;

    // Bench-side byte RAM (asynchronous read, write on rising edge) with a
    // poke port for preloading.
    logic [7:0]  mem [0:1023] = '{default: 8'h00};
    logic        pk_en = 1'b0;
    logic [9:0]  pk_a  = '0;
    logic [7:0]  pk_d  = '0;

    // Reference state: expected memory contents and expected rdata.
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] exp_rdata;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sx;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];

    always @(posedge clk) begin
        if (pk_en)
            mem[pk_a] <= pk_d;
        else if (ram_ena && ram_wena)
            mem[ram_addr] <= ram_din;
    end

    ram_byte_ctrl #(.ADDR_W(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ram_ena  (ram_ena),
        .ram_wena (ram_wena),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_en = 1'b1;
        pk_a  = a;
        pk_d  = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 pk_en = 1'b0;
    endtask

    function automatic int unsigned beats_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // One request from IDLE, observed for 10 cycles, checked against the model.
    task automatic txn(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [9:0] a, input logic [31:0] wd,
                       input logic [31:0] tbl_exp, input bit use_tbl);
        int unsigned n, base, k, done_cnt, err_cnt, idle_bad;
        int          done_at, err_at;
        bit          legal;
        logic [31:0] v;
        n = beats_of(sz);
`ifdef RAM_BYTE_CTRL_ALIGN_CHECK_EN
        legal = (sz != 2'd3) && ((int'(a) % n) == 0);
        base  = a;
`else
        legal = 1'b1;
        base  = int'(a) - (int'(a) % n);
`endif
        k = 0; done_cnt = 0; err_cnt = 0; idle_bad = 0; done_at = -1; err_at = -1;

        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ram_ena) begin
                check("beat_addr", 32'(ram_addr), 32'(base + k));
                check("beat_wena", 32'(ram_wena), 32'(w));
                if (w)
                    check("beat_din", 32'(ram_din), (wd >> (8 * (n - 1 - k))) & 32'hFF);
                k++;
            end else if (ram_wena || ram_addr != '0 || ram_din != '0) begin
                idle_bad++;
            end
            if (done) begin done_cnt++; done_at = c; end
            if (err)  begin err_cnt++;  err_at  = c; end
        end
        check("ram_idle_zero", idle_bad, 0);

        if (legal) begin
            check("beat_count", k, n);
            check("done_count", done_cnt, 1);
            check("done_cycle", 32'(done_at), 32'(n));
            check("err_count", err_cnt, 0);
            if (w) begin
                for (int unsigned j = 0; j < n; j++)
                    ref_mem[base + j] = 8'((wd >> (8 * (n - 1 - j))) & 32'hFF);
            end else begin
                v = '0;
                for (int unsigned j = 0; j < n; j++)
                    v = (v << 8) | 32'(ref_mem[base + j]);
                if (sx && n < 4 && v[8 * n - 1])
                    v = v | (32'hFFFF_FFFF << (8 * n));
                exp_rdata = v;
            end
        end else begin
            check("illegal_beats", k, 0);
            check("illegal_done", done_cnt, 0);
            check("err_count", err_cnt, 1);
            check("err_cycle", 32'(err_at), 32'd0);
        end
        check("rdata", rdata, exp_rdata);
        if (use_tbl)
            check("tbl_rdata", rdata, tbl_exp);
    endtask

    initial begin
        int unsigned ena_mask, done_mask, cnt;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        exp_rdata = '0;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = '0; sign_ext = 1'b0; addr = '0; wdata = '0;

        // Preload while reset is held.
        poke(10'h010, 8'h81); poke(10'h011, 8'h22);
        poke(10'h012, 8'h33); poke(10'h013, 8'h44);
        for (int i = 0; i < 4; i++) poke(10'(10'h030 + i), 8'hA5);

        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_ram", {ram_ena, ram_wena, ram_din, 12'(ram_addr)}, 32'h0);
        rst = 1'b0;

        // Directed table.
        tbl[0] = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,         32'h8122_3344};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 10'h010, 32'h0,         32'hFFFF_FF81};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 10'h010, 32'h0,         32'h0000_0081};
        tbl[3] = '{1'b0, 2'd1, 1'b1, 10'h012, 32'h0,         32'h0000_3344};
        tbl[4] = '{1'b1, 2'd2, 1'b0, 10'h020, 32'hDEAD_BEEF, 32'h0000_3344};
        tbl[5] = '{1'b1, 2'd0, 1'b0, 10'h021, 32'h0000_005A, 32'h0000_3344};
        tbl[6] = '{1'b0, 2'd2, 1'b0, 10'h020, 32'h0,         32'hDE5A_BEEF};
`ifdef RAM_BYTE_CTRL_ALIGN_CHECK_EN
        tbl[7] = '{1'b0, 2'd2, 1'b0, 10'h011, 32'h0,         32'hDE5A_BEEF};
`else
        tbl[7] = '{1'b0, 2'd2, 1'b0, 10'h011, 32'h0,         32'h8122_3344};
`endif
        foreach (tbl[i])
            txn(tbl[i].we, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b1);

        // Reset during beat 2 of sw 0x11223344 @0x30.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 10'h030; wdata = 32'h1122_3344;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_beat2_addr", 32'(ram_addr), 32'h032);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'h0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (done || ram_ena) cnt++;
            @(negedge clk);
        end
        check("rstmid_quiet", cnt, 0);
        check("rstmid_mem", {mem[10'h030], mem[10'h031], mem[10'h032], mem[10'h033]}, 32'h1122_A5A5);
        ref_mem[10'h030] = 8'h11;
        ref_mem[10'h031] = 8'h22;

        // rst and req together: request is dropped.
        rst = 1'b1; req = 1'b1; we = 1'b0; size = 2'd0; addr = 10'h010;
        @(posedge clk);
        #1 begin rst = 1'b0; req = 1'b0; end
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy || done || ram_ena) cnt++;
        end
        check("rst_req_dropped", cnt, 0);

        // req held high: lb 0x13 accepted every third edge.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd0; sign_ext = 1'b1; addr = 10'h013;
        @(posedge clk);
        ena_mask = 0; done_mask = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (ram_ena && ram_addr == 10'h013) ena_mask |= (1 << c);
            if (done) done_mask |= (1 << c);
        end
        req = 1'b0;
        check("held_req_beats", ena_mask, 32'h049);
        check("held_req_dones", done_mask, 32'h092);
        repeat (3) @(negedge clk);
        check("held_req_rdata", rdata, 32'h0000_0044);
        exp_rdata = 32'h0000_0044;

        // Randomised traffic in a private window, checked by the model.
        for (int t = 0; t < 200; t++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                10'(10'h100 + $urandom_range(0, 63)), $urandom, 32'h0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_byte_ctrl.md
# ram_byte_ctrl

Load/store sequencer between the CPU memory stage and the byte-wide `ram` data memory (WIDTH=8). It turns one 32-bit byte, half or word request into 1, 2 or 4 sequential single-byte RAM accesses. Byte order is big-endian, as in MIPS. On loads it assembles the bytes and sign- or zero-extends them; it signals completion with a one-cycle `done` pulse.

## Interface
- ADDR_W, 10, byte address width; equals the attached RAM's DEPTH.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified for byte and half.
- rdata  out  32  load result; held until the next load completes.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when a request is rejected.
- ram_ena  out  1  RAM enable.
- ram_wena  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_din  out  8  RAM write byte.
- ram_dout  in  8  RAM read byte; asynchronous, valid in the same cycle as `ram_addr`.

## Operation
- FSM states:
  - IDLE, on `req`: if the request is legal, latch `we`, `size`, `sign_ext`, `addr`, `wdata`, set N = 1/2/4 and beat index i = 0, go to BEAT. If illegal, go to ERR.
  - ERR: `err`=1 for one cycle, no RAM access, then IDLE.
  - BEAT: `ram_ena`=1, `ram_wena`=`we`, `ram_addr`=base+i. Each cycle i increments. After beat i = N-1, go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Illegal request: size=11, half with addr[0]=1, or word with addr[1:0]≠0.
- Store bytes, MSB first, within the access:
  - word: wdata[31:24], [23:16], [15:8], [7:0].
  - half: wdata[15:8], [7:0].
  - byte: wdata[7:0].
- Loads:
  - Accumulator acc <= {acc[23:0], ram_dout} at each beat edge.
  - On the edge entering DONE, `rdata` <= acc extended from 8/16/32 bits according to `sign_ext`.
  - Store accesses leave `rdata` unchanged.
- Outside BEAT: `ram_ena`=0, `ram_wena`=0, `ram_addr`=0, `ram_din`=0.
- Address wrap: aligned accesses never cross 2^ADDR_W. base+i needs no wrap handling.
- `req` is ignored while in BEAT, DONE or ERR; the master must re-present it. It is not queued.

## Timing
- Count the edge that samples `req` in IDLE as edge 0.
- Beats occupy the cycles after edges 0 … N-1; writes commit at edges 1 … N.
- `done` is high in the cycle after edge N. The next `req` is accepted at edge N+2.
- Request occupancy: byte 3 cycles, half 4 cycles, word 6 cycles (N+2).
- `err` is high in the cycle after edge 0. The next `req` is accepted at edge 2.
- Reset values: state IDLE, `rdata`=0, `busy`=0, `done`=0, `err`=0. All RAM outputs are 0.
- Reset mid-operation: abort on the reset edge with no `done`. Bytes already written stay written.
- `rst` and `req` in the same cycle: reset wins and the request is dropped.

## Configuration
- RAM_BYTE_CTRL_ALIGN_CHECK_EN defined: misaligned or size=11 requests go to ERR as described above.
- Macro undefined:
  - `err` is tied to 0 and the ERR state is absent.
  - Half accesses clear addr[0]; word accesses clear addr[1:0].
  - size=11 is treated as word.

## Structure
- Shared package `mem_pkg` holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encoding S_IDLE, S_BEAT, S_DONE, S_ERR;
  - beat-count function size → N.
- One combinational sub-module, `load_extend`: inputs acc, size, sign_ext; output 32-bit `rdata` value.
- The `ram` instance lives in the parent, not inside this block.

## Test plan
Preload RAM bytes 0x10..0x13 with 81 22 33 44.
- lw 0x10 → `ram_addr` 0x10,0x11,0x12,0x13 on consecutive cycles; `done` in the cycle after edge 4; `rdata`=0x81223344.
- lb 0x10: sign_ext=1 → 0xFFFFFF81; sign_ext=0 → 0x00000081. lh 0x12 sign → 0x00003344.
- sw 0xDEADBEEF @0x20, then sb 0x5A @0x21, then lw 0x20 → 0xDE5ABEEF; `rdata` unchanged after each store.
- lw 0x11 with macro defined → `err` pulse in the cycle after edge 0, `ram_ena` never high, no `done`. Without macro → reads 0x10 → 0x81223344.
- sw 0x11223344 @0x30 with `rst` asserted during beat 2 (the cycle with `ram_addr`=0x32) → IDLE after that edge, `busy`=0, no `done`. Bytes 0x30=0x11 and 0x31=0x22 are written; 0x32 and 0x33 keep their old values.
- `req` held high continuously with lb 0x13 → accepted at edges 0, 3, 6; exactly one `done` per acceptance; `rdata`=0x00000044 with sign_ext=1.
